lookupflow_cmd: RTL
===================

Name: lookupflow_cmd

Overview:
- Next-generation flow-lookup front end for an NPORT-port switch.
- Drains a 9-bit RX-FIFO byte stream, parses Ethernet/IPv4/UDP headers per frame and detects command frames: UDP destination port and magic word are both parameters.
- Atomically commits a per-port forwarding table carried in the command payload.
- Serves a registered req/ack/err lookup for the local port. Replaces the unfiltered, partially-updated, fixed 4-port parser.

Parameters:
- NPORT, 4, number of switch ports / table entries (1..8).
- PORT_NUM, 0, index of the local port served by the lookup handshake (0..NPORT-1).
- CMD_UDP_PORT, 16'd3776, UDP destination port identifying command frames.
- MAGIC_CODE, 32'hC0C0C0CC, magic word required at payload offset 0x2a.
- FILTER_EN, 1, 1: commit only on a full header match; 0: commit any sufficiently long frame.
- DEFAULT_PORT, 4'h0, reset value of every table nibble.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_dout  in  9  FIFO data; [8]=1 in-frame byte, [8]=0 end-of-frame marker, [7:0] byte.
- rx_empty  in  1  FIFO empty.
- rx_rd_en  out  1  FIFO read enable.
- of_lookup_req  in  1  lookup request, 1-cycle pulse.
- of_lookup_ack  out  1  lookup acknowledge, 1-cycle pulse.
- of_lookup_err  out  1  lookup returned without a programmed table.
- of_lookup_fwd_port  out  4  forward port nibble for PORT_NUM.
- of_table  out  4*NPORT  full committed table, nibble i = port i.
- of_table_valid  out  1  set once any command frame has committed.
- cmd_cnt  out  16  committed command frames, wraps.
- drop_cnt  out  16  frames ended without commit, wraps.

Behaviour:
- Reset (async assert, sync release): rx_rd_en=0, all outputs 0 except of_table={NPORT{DEFAULT_PORT}}. Offset counter=0, shadow/header registers 0, state IDLE.
- Read path:
  - rx_rd_en = ~rx_empty (combinational, forced 0 in reset).
  - rd_vld <= rx_rd_en. FIFO has 1-cycle read latency, so rx_dout is valid and consumed only when rd_vld=1.
  - No other byte is consumed.
- Offset counter, 11 bits, 0 at first in-frame byte:
  - increments per consumed byte with [8]=1; saturates at 2047 (no wrap).
  - cleared when a byte with [8]=0 is consumed.
- Header capture on consumed in-frame bytes:
  - ethertype at offsets 0x0c–0x0d, must equal 16'h0800.
  - version/IHL at 0x0e, must equal 8'h45.
  - IPv4 protocol at 0x17, must equal 8'h11.
  - UDP dst port at 0x24–0x25, must equal CMD_UDP_PORT.
  - magic at 0x2a–0x2d, must equal MAGIC_CODE.
  - payload byte 0x2e+i, i<NPORT: low nibble written to shadow entry i; live table untouched.
- FSM:
  - IDLE: first consumed in-frame byte -> PARSE.
  - PARSE: consumed byte with [8]=0 -> EVAL.
  - EVAL: single cycle, then -> IDLE. Condition is len >= 0x2e+NPORT and (FILTER_EN=0 or all five fields match).
    - Condition true: of_table <= shadow, of_table_valid <= 1, cmd_cnt+1.
    - Condition false: drop_cnt+1; table unchanged.
  - End marker while in IDLE (empty frame): ignored, no count.
  - Byte consumed in EVAL cycle: counts as the first byte of the next frame, offset 0. The next frame may start immediately.
- Commit is atomic: of_table never shows a mix of two frames.
- Lookup:
  - of_lookup_req=1 -> next cycle of_lookup_ack=1 and of_lookup_fwd_port=of_table[PORT_NUM].
  - of_lookup_err = ~of_table_valid in that same cycle.
  - ack/err are 1-cycle pulses.
  - fwd_port holds until the next ack.
  - Req coinciding with a commit cycle returns the pre-commit value.
  - Back-to-back reqs give back-to-back acks.
- Reset mid-frame: the partial frame is discarded, no counter updates, table returns to DEFAULT_PORT.

Test Plan:
- Matching command frame, NPORT=4, payload 0x2e..0x31 = 03,02,01,00, end marker -> 2 cycles after marker consumed: of_table=16'h0123, of_table_valid=1, cmd_cnt=1.
- Same frame with magic C0C0C0CD -> of_table unchanged (DEFAULT), drop_cnt=1, cmd_cnt=0. Repeat with FILTER_EN=0 -> commit.
- Matching frame truncated at length 0x30 -> drop_cnt=1, no partial nibble visible on of_table.
- of_lookup_req before any commit -> ack=1, err=1, fwd_port=DEFAULT_PORT. After commit with PORT_NUM=2 -> ack=1, err=0, fwd_port=4'h1.
- Two matching frames back-to-back, rx_empty toggling randomly inside frames -> cmd_cnt=2, table equals second frame's payload, offsets unaffected by stalls.
- Assert sys_rst_n low at offset 0x2f of a matching frame -> all outputs at reset values immediately; next full frame commits correctly.

Source files
------------

// File: rtl/lookupflow_cmd.sv
// Flow-lookup front end: parses Ethernet/IPv4/UDP command frames from an RX FIFO
// and atomically commits the per-port forwarding table they carry.
module lookupflow_cmd #(
    parameter int unsigned NPORT        = 4,
    parameter int unsigned PORT_NUM     = 0,
    parameter logic [15:0] CMD_UDP_PORT = 16'd3776,
    parameter logic [31:0] MAGIC_CODE   = 32'hC0C0C0CC,
    parameter bit          FILTER_EN    = 1'b1,
    parameter logic [3:0]  DEFAULT_PORT = 4'h0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [8:0]           rx_dout,
    input  logic                 rx_empty,
    output logic                 rx_rd_en,
    input  logic                 of_lookup_req,
    output logic                 of_lookup_ack,
    output logic                 of_lookup_err,
    output logic [3:0]           of_lookup_fwd_port,
    output logic [4*NPORT-1:0]   of_table,
    output logic                 of_table_valid,
    output logic [15:0]          cmd_cnt,
    output logic [15:0]          drop_cnt
);
    localparam logic [10:0] PAYLOAD_OFF = 11'h02e;
    localparam logic [10:0] MIN_LEN     = 11'(46 + NPORT);

    typedef enum logic [1:0] {ST_IDLE, ST_PARSE, ST_EVAL} state_t;

    state_t               state_r, state_s;
    logic                 rd_vld_r;
    logic [10:0]          off_r, len_r;
    logic [15:0]          eth_r, udp_r;
    logic [7:0]           ver_r, proto_r;
    logic [31:0]          magic_r;
    logic [4*NPORT-1:0]   shadow_r, table_r;
    logic                 tv_r, ack_r, err_r;
    logic [3:0]           fwd_r;
    logic [15:0]          cmd_r, drop_r;
    logic                 in_byte_s, end_s, match_s, commit_s, drop_s;

    assign rx_rd_en  = sys_rst_n & ~rx_empty;
    assign in_byte_s = rd_vld_r &  rx_dout[8];
    assign end_s     = rd_vld_r & ~rx_dout[8];
    assign match_s   = (eth_r == 16'h0800) && (ver_r == 8'h45) && (proto_r == 8'h11) &&
                       (udp_r == CMD_UDP_PORT) && (magic_r == MAGIC_CODE);

    // FIFO read latency tracking, byte offset and frame length capture
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_vld_r <= 1'b0;
            off_r    <= 11'd0;
            len_r    <= 11'd0;
        end else begin
            rd_vld_r <= rx_rd_en;
            if (in_byte_s) begin
                if (off_r != 11'h7ff) begin
                    off_r <= off_r + 11'd1;
                end
            end else if (end_s) begin
                off_r <= 11'd0;
                len_r <= off_r;
            end
        end
    end

    // Header field and shadow table capture at fixed byte offsets
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            eth_r    <= 16'h0000;
            ver_r    <= 8'h00;
            proto_r  <= 8'h00;
            udp_r    <= 16'h0000;
            magic_r  <= 32'h0000_0000;
            shadow_r <= '0;
        end else if (in_byte_s) begin
            case (off_r)
                11'h00c: eth_r[15:8]    <= rx_dout[7:0];
                11'h00d: eth_r[7:0]     <= rx_dout[7:0];
                11'h00e: ver_r          <= rx_dout[7:0];
                11'h017: proto_r        <= rx_dout[7:0];
                11'h024: udp_r[15:8]    <= rx_dout[7:0];
                11'h025: udp_r[7:0]     <= rx_dout[7:0];
                11'h02a: magic_r[31:24] <= rx_dout[7:0];
                11'h02b: magic_r[23:16] <= rx_dout[7:0];
                11'h02c: magic_r[15:8]  <= rx_dout[7:0];
                11'h02d: magic_r[7:0]   <= rx_dout[7:0];
                default: ;
            endcase
            for (int i = 0; i < int'(NPORT); i++) begin
                if (off_r == PAYLOAD_OFF + 11'(i)) begin
                    shadow_r[i*4 +: 4] <= rx_dout[3:0];
                end
            end
        end
    end

    // Frame state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and commit decision; a byte arriving during EVAL opens the next frame
    always_comb begin
        state_s  = state_r;
        commit_s = 1'b0;
        drop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_byte_s) state_s = ST_PARSE;
                else           state_s = ST_IDLE;
            end
            ST_PARSE: begin
                if (end_s) state_s = ST_EVAL;
                else       state_s = ST_PARSE;
            end
            ST_EVAL: begin
                if ((len_r >= MIN_LEN) && (!FILTER_EN || match_s)) commit_s = 1'b1;
                else                                               drop_s   = 1'b1;
                if (in_byte_s) state_s = ST_PARSE;
                else           state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Live table and frame counters; table is replaced whole from the shadow
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            table_r <= {NPORT{DEFAULT_PORT}};
            tv_r    <= 1'b0;
            cmd_r   <= 16'h0000;
            drop_r  <= 16'h0000;
        end else if (commit_s) begin
            table_r <= shadow_r;
            tv_r    <= 1'b1;
            cmd_r   <= cmd_r + 16'h0001;
        end else if (drop_s) begin
            drop_r  <= drop_r + 16'h0001;
        end
    end

    // Lookup handshake; a request sees the table as it stood before this edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            fwd_r <= 4'h0;
        end else begin
            ack_r <= of_lookup_req;
            err_r <= of_lookup_req & ~tv_r;
            if (of_lookup_req) begin
                fwd_r <= table_r[PORT_NUM*4 +: 4];
            end
        end
    end

    assign of_table           = table_r;
    assign of_table_valid     = tv_r;
    assign cmd_cnt            = cmd_r;
    assign drop_cnt           = drop_r;
    assign of_lookup_ack      = ack_r;
    assign of_lookup_err      = err_r;
    assign of_lookup_fwd_port = fwd_r;
endmodule
